// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter: counting-mode encodings and decode.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_FREE    = 2'd0,
        MODE_MOD     = 2'd1,
        MODE_ONESHOT = 2'd2
    } mode_e;

    // The reserved encoding 3 behaves exactly like FREE.
    function automatic mode_e mode_decode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_MOD;
            2'd2:    return MODE_ONESHOT;
            default: return MODE_FREE;
        endcase
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable-gated prescaler: one tick every prescale+1 enabled cycles.
module counter_prescaler #(
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] prescale,
    output logic               tick
);
    localparam logic [PRESC_W-1:0] P_ZERO = {PRESC_W{1'b0}};
    localparam logic [PRESC_W-1:0] P_ONE  = {{(PRESC_W-1){1'b0}}, 1'b1};

    logic [PRESC_W-1:0] cnt_r;

    assign tick = en && (cnt_r == prescale);

    // Prescale counter: cleared by load, wraps to zero on each tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= P_ZERO;
        end else if (clr) begin
            cnt_r <= P_ZERO;
        end else if (tick) begin
            cnt_r <= P_ZERO;
        end else if (en) begin
            cnt_r <= cnt_r + P_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/updown_counter.sv
// Prescaled up/down counter with free-running, modulo and one-shot modes,
// terminal-count pulse, compare match and load.
module updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic               dir,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [WIDTH-1:0]   modulo,
    input  logic [PRESC_W-1:0] prescale,
    input  logic [WIDTH-1:0]   cmp,
    output logic [WIDTH-1:0]   out,
    output logic               tc,
    output logic               match,
    output logic               done
);
    localparam logic [WIDTH-1:0] V_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] V_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] V_MAX  = {WIDTH{1'b1}};

    logic [WIDTH-1:0] out_r;
    logic             tc_r;
    logic             done_r;
    logic             tick_s;
    mode_e            mode_s;
    logic [WIDTH-1:0] step_s;
    logic [WIDTH-1:0] term_s;
    logic [WIDTH-1:0] next_out_s;
    logic             next_tc_s;
    logic             next_done_s;

    counter_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .clr      (load),
        .prescale (prescale),
        .tick     (tick_s)
    );

    assign mode_s = mode_decode(mode);
    assign step_s = dir ? (out_r + V_ONE) : (out_r - V_ONE);
    assign term_s = dir ? modulo : V_ZERO;

    // Next count, terminal pulse and done flag for a tick in the current mode.
    always_comb begin
        next_out_s  = out_r;
        next_tc_s   = 1'b0;
        next_done_s = done_r;
        case (mode_s)
            MODE_MOD: begin
                if (dir) begin
                    if (out_r >= modulo) begin
                        next_out_s = V_ZERO;
                        next_tc_s  = 1'b1;
                    end else begin
                        next_out_s = step_s;
                    end
                end else begin
                    if ((out_r == V_ZERO) || (out_r > modulo)) begin
                        next_out_s = modulo;
                        next_tc_s  = 1'b1;
                    end else begin
                        next_out_s = step_s;
                    end
                end
            end
            MODE_ONESHOT: begin
                // Once done, the counter is frozen and tc stays quiet.
                if (done_r) begin
                    next_out_s = out_r;
                end else if (out_r == term_s) begin
                    next_done_s = 1'b1;
                    next_tc_s   = 1'b1;
                end else begin
                    next_out_s = step_s;
                end
            end
            default: begin
                next_out_s = step_s;
                next_tc_s  = dir ? (out_r == V_MAX) : (out_r == V_ZERO);
            end
        endcase
    end

    // Count state: load outranks ticks; tc is a single-cycle pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_r  <= V_ZERO;
            tc_r   <= 1'b0;
            done_r <= 1'b0;
        end else if (load) begin
            out_r  <= load_val;
            tc_r   <= 1'b0;
            done_r <= 1'b0;
        end else if (tick_s) begin
            out_r  <= next_out_s;
            tc_r   <= next_tc_s;
            done_r <= next_done_s;
        end else begin
            out_r  <= out_r;
            tc_r   <= 1'b0;
            done_r <= done_r;
        end
    end

    assign out   = out_r;
    assign tc    = tc_r;
    assign done  = done_r;
    assign match = (out_r == cmp);

endmodule

// File: tb/tb_updown_counter.sv
// Self-checking bench for updown_counter: directed vector table, multi-cycle
// corner sequences and a randomized run against an arithmetic reference model.
module tb_updown_counter;

    localparam int MAXV = 256;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic       dir;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] modulo;
    logic [3:0] prescale;
    logic [7:0] cmp;
    logic [7:0] out;
    logic       tc;
    logic       match;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (plain integers)
    int m_out, m_done, m_tc, m_en_cycles;

    updown_counter #(.WIDTH(8), .PRESC_W(4)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .dir(dir),
        .load(load), .load_val(load_val), .modulo(modulo),
        .prescale(prescale), .cmp(cmp), .out(out), .tc(tc),
        .match(match), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ld;
        logic [7:0] lv;
        logic       en;
        logic [1:0] md;
        logic       dr;
        logic [7:0] mo;
        logic [7:0] e_out;
        logic       e_tc;
        logic       e_done;
        logic       e_match;
    } vec_t;

    vec_t vecs[27];

    function automatic vec_t mkv(logic ld, logic [7:0] lv, logic e, logic [1:0] md,
                                 logic dr, logic [7:0] mo, logic [7:0] eo,
                                 logic et, logic ed, logic em);
        vec_t v;
        v.ld = ld; v.lv = lv; v.en = e; v.md = md; v.dr = dr; v.mo = mo;
        v.e_out = eo; v.e_tc = et; v.e_done = ed; v.e_match = em;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out = 0; m_done = 0; m_tc = 0; m_en_cycles = 0;
    endtask

    // Advance the model by one clock from the current inputs.
    task automatic model_step();
        bit tick;
        tick = 1'b0;
        m_tc = 0;
        if (load) begin
            m_out = int'(load_val); m_done = 0; m_en_cycles = 0;
        end else if (en) begin
            m_en_cycles++;
            if (m_en_cycles == int'(prescale) + 1) begin
                m_en_cycles = 0;
                tick = 1'b1;
            end
        end
        if (tick) begin
            if (mode == 2'd1) begin
                if (dir) begin
                    if (m_out >= int'(modulo)) begin m_out = 0; m_tc = 1; end
                    else m_out = m_out + 1;
                end else begin
                    if (m_out == 0 || m_out > int'(modulo)) begin m_out = int'(modulo); m_tc = 1; end
                    else m_out = m_out - 1;
                end
            end else if (mode == 2'd2) begin
                if (m_done == 0) begin
                    if (m_out == (dir ? int'(modulo) : 0)) begin m_done = 1; m_tc = 1; end
                    else m_out = dir ? (m_out + 1) % MAXV : (m_out + MAXV - 1) % MAXV;
                end
            end else begin
                if (dir) begin m_tc = (m_out == MAXV - 1); m_out = (m_out + 1) % MAXV; end
                else begin m_tc = (m_out == 0); m_out = (m_out + MAXV - 1) % MAXV; end
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".out"},   32'(out),   32'(m_out));
        chk({tag, ".tc"},    32'(tc),    32'(m_tc));
        chk({tag, ".done"},  32'(done),  32'(m_done));
        chk({tag, ".match"}, 32'(match), 32'(m_out == int'(cmp)));
    endtask

    initial begin
        int tc_cnt;
        // Directed table, prescale=0, cmp=0x10 throughout
        vecs[0]  = mkv(1'b1, 8'hFE, 1'b1, 2'd0, 1'b1, 8'd5, 8'hFE, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mkv(1'b0, 8'h00, 1'b1, 2'd0, 1'b1, 8'd5, 8'hFF, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mkv(1'b0, 8'h00, 1'b1, 2'd0, 1'b1, 8'd5, 8'h00, 1'b1, 1'b0, 1'b0);
        vecs[3]  = mkv(1'b0, 8'h00, 1'b1, 2'd0, 1'b1, 8'd5, 8'h01, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mkv(1'b1, 8'h00, 1'b1, 2'd1, 1'b1, 8'd5, 8'h00, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mkv(1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'd5, 8'h01, 1'b0, 1'b0, 1'b0);
        vecs[6]  = mkv(1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'd5, 8'h02, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mkv(1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'd5, 8'h03, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mkv(1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'd5, 8'h04, 1'b0, 1'b0, 1'b0);
        vecs[9]  = mkv(1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'd5, 8'h05, 1'b0, 1'b0, 1'b0);
        vecs[10] = mkv(1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'd5, 8'h00, 1'b1, 1'b0, 1'b0);
        vecs[11] = mkv(1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'd5, 8'h01, 1'b0, 1'b0, 1'b0);
        vecs[12] = mkv(1'b1, 8'h09, 1'b1, 2'd1, 1'b0, 8'd5, 8'h09, 1'b0, 1'b0, 1'b0);
        vecs[13] = mkv(1'b0, 8'h00, 1'b1, 2'd1, 1'b0, 8'd5, 8'h05, 1'b1, 1'b0, 1'b0);
        vecs[14] = mkv(1'b0, 8'h00, 1'b1, 2'd1, 1'b0, 8'd5, 8'h04, 1'b0, 1'b0, 1'b0);
        vecs[15] = mkv(1'b1, 8'h0E, 1'b1, 2'd0, 1'b1, 8'd5, 8'h0E, 1'b0, 1'b0, 1'b0);
        vecs[16] = mkv(1'b0, 8'h00, 1'b1, 2'd0, 1'b1, 8'd5, 8'h0F, 1'b0, 1'b0, 1'b0);
        vecs[17] = mkv(1'b0, 8'h00, 1'b1, 2'd0, 1'b1, 8'd5, 8'h10, 1'b0, 1'b0, 1'b1);
        vecs[18] = mkv(1'b0, 8'h00, 1'b1, 2'd0, 1'b1, 8'd5, 8'h11, 1'b0, 1'b0, 1'b0);
        vecs[19] = mkv(1'b1, 8'h10, 1'b1, 2'd0, 1'b1, 8'd5, 8'h10, 1'b0, 1'b0, 1'b1);
        vecs[20] = mkv(1'b1, 8'h20, 1'b0, 2'd0, 1'b1, 8'd5, 8'h20, 1'b0, 1'b0, 1'b0);
        vecs[21] = mkv(1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 8'd5, 8'h20, 1'b0, 1'b0, 1'b0);
        vecs[22] = mkv(1'b1, 8'h02, 1'b1, 2'd2, 1'b0, 8'd5, 8'h02, 1'b0, 1'b0, 1'b0);
        vecs[23] = mkv(1'b0, 8'h00, 1'b1, 2'd2, 1'b0, 8'd5, 8'h01, 1'b0, 1'b0, 1'b0);
        vecs[24] = mkv(1'b0, 8'h00, 1'b1, 2'd2, 1'b0, 8'd5, 8'h00, 1'b0, 1'b0, 1'b0);
        vecs[25] = mkv(1'b0, 8'h00, 1'b1, 2'd2, 1'b0, 8'd5, 8'h00, 1'b1, 1'b1, 1'b0);
        vecs[26] = mkv(1'b0, 8'h00, 1'b1, 2'd2, 1'b0, 8'd5, 8'h00, 1'b0, 1'b1, 1'b0);

        reset = 1'b1; en = 1'b0; mode = 2'd0; dir = 1'b1; load = 1'b0;
        load_val = 8'h00; modulo = 8'h00; prescale = 4'd0; cmp = 8'h10;
        model_reset();
        #12;
        chk("reset.out", 32'(out), 32'h0);
        chk("reset.tc", 32'(tc), 32'h0);
        chk("reset.done", 32'(done), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 27; i++) begin
            load = vecs[i].ld; load_val = vecs[i].lv; en = vecs[i].en;
            mode = vecs[i].md; dir = vecs[i].dr; modulo = vecs[i].mo;
            cycle();
            chk($sformatf("vec%0d.out", i),   32'(out),   32'(vecs[i].e_out));
            chk($sformatf("vec%0d.tc", i),    32'(tc),    32'(vecs[i].e_tc));
            chk($sformatf("vec%0d.done", i),  32'(done),  32'(vecs[i].e_done));
            chk($sformatf("vec%0d.match", i), 32'(match), 32'(vecs[i].e_match));
        end

        // One-shot up to 3 with a tick every third enabled cycle
        mode = 2'd2; dir = 1'b1; modulo = 8'd3; prescale = 4'd2; en = 1'b1;
        load = 1'b1; load_val = 8'd0;
        cycle();
        load = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            cycle(); chk("os.wait1", 32'(out), 32'(t - 1));
            cycle(); chk("os.wait2", 32'(out), 32'(t - 1));
            cycle(); chk("os.step", 32'(out), 32'(t));
            chk("os.step_tc", 32'(tc), 32'h0);
        end
        cycle(); cycle(); cycle();
        chk("os.term_out", 32'(out), 32'd3);
        chk("os.term_done", 32'(done), 32'h1);
        chk("os.term_tc", 32'(tc), 32'h1);
        tc_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            cycle();
            if (tc) tc_cnt++;
            chk("os.hold_out", 32'(out), 32'd3);
        end
        chk("os.extra_tc", 32'(tc_cnt), 32'h0);
        chk("os.hold_done", 32'(done), 32'h1);
        load = 1'b1; load_val = 8'd0;
        cycle();
        load = 1'b0;
        chk("os.reload_done", 32'(done), 32'h0);
        chk("os.reload_out", 32'(out), 32'h0);

        // Reset mid-count at 0x42 with the prescaler at 1
        mode = 2'd0; dir = 1'b1; prescale = 4'd2; en = 1'b1;
        load = 1'b1; load_val = 8'h41;
        cycle();
        load = 1'b0;
        for (int c = 0; c < 4; c++) cycle();
        chk("rst.pre_out", 32'(out), 32'h42);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst.async_out", 32'(out), 32'h0);
        chk("rst.async_tc", 32'(tc), 32'h0);
        chk("rst.async_done", 32'(done), 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cycle(); chk("rst.post1", 32'(out), 32'h0);
        cycle(); chk("rst.post2", 32'(out), 32'h0);
        cycle(); chk("rst.post3", 32'(out), 32'h1);

        // Randomized run against the reference model
        for (int c = 0; c < 600; c++) begin
            load = (c == 0) || ($urandom_range(0, 19) == 0);
            if (load) begin
                load_val = 8'($urandom_range(0, 255));
                prescale = 4'($urandom_range(0, 3));
            end
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) dir = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) modulo = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 15) == 0) cmp = 8'($urandom_range(0, 12));
            cycle();
            chk_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_counter.md
UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the counter width in bits (WIDTH >= 2).
REQ-002 The module SHALL have parameter PRESC_W, default 4, giving the prescaler width in bits (PRESC_W >= 1).
REQ-003 The module SHALL have port clk, input, 1 bit: clock; all state SHALL update on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The module SHALL have port en, input, 1 bit: count enable, gating prescaler and counter.
REQ-006 The module SHALL have port mode, input, 2 bits: counting mode; FREE=0, MOD=1, ONESHOT=2, 3 reserved and treated as FREE.
REQ-007 The module SHALL have port dir, input, 1 bit: direction; 1=up, 0=down.
REQ-008 The module SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-009 The module SHALL have port load_val, input, WIDTH bits: value written to out on load.
REQ-010 The module SHALL have port modulo, input, WIDTH bits: wrap/terminal bound for MOD and ONESHOT.
REQ-011 The module SHALL have port prescale, input, PRESC_W bits: a tick occurs every prescale+1 enabled cycles.
REQ-012 The module SHALL have port cmp, input, WIDTH bits: compare value.
REQ-013 The module SHALL have port out, output, WIDTH bits: registered count value.
REQ-014 The module SHALL have port tc, output, 1 bit: registered one-cycle terminal-count pulse.
REQ-015 The module SHALL have port match, output, 1 bit: high while out == cmp, combinational from the out register.
REQ-016 The module SHALL have port done, output, 1 bit: ONESHOT finished; counter is holding.

Function
REQ-017 The prescaler SHALL increment on each cycle with en=1, issue a tick and clear when it equals prescale, and hold when en=0; prescale=0 SHALL give a tick every enabled cycle.
REQ-018 out SHALL change only on a tick or on load; its latency is one clock after the tick cycle.
REQ-019 load SHALL have priority over counting regardless of en: out=load_val, prescaler=0, done=0, tc=0 on the next edge.
REQ-020 In FREE mode, a tick SHALL step out by ±1 modulo 2^WIDTH; tc SHALL pulse on the 2^WIDTH-1→0 (up) or 0→2^WIDTH-1 (down) transition.
REQ-021 In MOD mode up, a tick with out >= modulo SHALL set out=0 and pulse tc; otherwise out SHALL be incremented.
REQ-022 In MOD mode down, a tick with out==0 or out>modulo SHALL set out=modulo and pulse tc; otherwise out SHALL be decremented.
REQ-023 In ONESHOT mode, the terminal value SHALL be modulo (up) or 0 (down); on a tick at terminal, out SHALL hold, done SHALL be set, and tc SHALL pulse once only.
REQ-024 While done=1, ticks SHALL NOT change out; done SHALL clear only on load or reset.
REQ-025 A change of mode, dir or modulo SHALL take effect at the next tick, with no state clearing.
REQ-026 tc SHALL be 0 on every cycle other than the cycle after a wrap or terminal event.

Reset
REQ-027 While reset=1, out SHALL be 0, tc=0, done=0, and the prescaler SHALL be 0, asynchronously.
REQ-028 Reset asserted mid-operation SHALL abort any prescale count; the first tick after release SHALL occur prescale+1 enabled cycles later.

Structure
REQ-029 Mode encodings (FREE, MOD, ONESHOT) SHALL be an enum typedef in the shared package counter_pkg.
REQ-030 The prescaler SHALL be a sub-module named counter_prescaler (PRESC_W parameter; en, clr, prescale in; tick out).

Verification
REQ-031 FREE, up, WIDTH=8, prescale=0: load 0xFE, then 3 ticks -> out 0xFF, 0x00, 0x01; tc=1 exactly the cycle out=0x00.
REQ-032 MOD, up, modulo=5: from 0, 7 ticks -> out 1,2,3,4,5,0,1; one tc pulse.
REQ-033 MOD, down, modulo=5, load 9: one tick -> out=5, tc pulse.
REQ-034 ONESHOT, up, modulo=3, prescale=2: from 0, tick every 3rd enabled cycle -> out reaches 3, done=1, single tc; 10 further ticks leave out=3; load 0 clears done.
REQ-035 Reset mid-count at out=0x42 with prescaler=1 -> out=0, done=0, tc=0 immediately; with en held, the first increment comes 3 cycles after release (prescale=2).
REQ-036 cmp=0x10, FREE up from 0x0E -> match=1 only while out=0x10; load and tick in the same cycle -> load wins.
